button_event_ctrl: RTL and testbench

- Sits between the raw push-button pins and the Nios system bus.
- Replaces a bare PIO input with per-button synchronisation, debounce, press-event capture and hold-to-repeat sequencing.
- Exposes an Avalon-MM slave (level, event, mask, repeat-enable registers) and a level interrupt, so software sees clean, countable presses instead of sampling bouncing inputs.

---
 rtl/button_pkg.sv | 16 +
 rtl/button_channel.sv | 114 +++++++++++
 rtl/button_event_ctrl.sv | 96 +++++++++
 tb/tb_button_event_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button event controller: register map
// and per-channel state encoding.
package button_pkg;

  localparam logic [1:0] ADDR_LEVEL  = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } chan_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce counter and press/hold-to-repeat
// sequencer producing a single-cycle event pulse.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic repeat_en,
  output logic level,
  output logic ev
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      t_q      <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      t_q      <= t_d;
    end
  end

  // Synchroniser works on the inverted pin so that 1 means pressed downstream.
  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
  end

  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (sync2_q != stable_q) begin
      if (dcnt_q == DB_LAST) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ev      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // IDLE is only ever entered with stable low, so a high level is a rising edge.
        if (stable_q) begin
          ev      = 1'b1;
          t_d     = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (t_q == RD_LAST) begin
          if (repeat_en) begin
            ev      = 1'b1;
            t_d     = '0;
            state_d = REPEAT;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (!repeat_en) begin
          // Park in HOLD with the delay already expired so re-enabling resumes at once.
          state_d = HOLD;
          t_d     = RD_LAST;
        end else if (t_q == RR_LAST) begin
          ev  = 1'b1;
          t_d = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign level = stable_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Avalon-MM push-button controller: per-button channels plus the LEVEL,
// EVENT (W1C), MASK and REPEAT_EN registers and a level interrupt.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] ev;
  logic [NUM_BTN-1:0] clear;
  logic [NUM_BTN-1:0] event_q, event_d;
  logic [NUM_BTN-1:0] mask_q, mask_d;
  logic [NUM_BTN-1:0] repen_q, repen_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_in[i]),
      .repeat_en (repen_q[i]),
      .level     (level[i]),
      .ev        (ev[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q    <= '0;
      mask_q     <= '0;
      repen_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      event_q    <= event_d;
      mask_q     <= mask_d;
      repen_q    <= repen_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    clear   = '0;
    mask_d  = mask_q;
    repen_d = repen_q;
    if (write) begin
      unique case (address)
        ADDR_EVENT:  clear   = writedata[NUM_BTN-1:0];
        ADDR_MASK:   mask_d  = writedata[NUM_BTN-1:0];
        ADDR_REPEAT: repen_d = writedata[NUM_BTN-1:0];
        default:     ;
      endcase
    end
    // A new event in the same cycle as its W1C clear must not be lost.
    event_d = (event_q & ~clear) | ev;
    irq_d   = |(event_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_LEVEL:  readdata_d[NUM_BTN-1:0] = level;
      ADDR_EVENT:  readdata_d[NUM_BTN-1:0] = event_q;
      ADDR_MASK:   readdata_d[NUM_BTN-1:0] = mask_q;
      ADDR_REPEAT: readdata_d[NUM_BTN-1:0] = repen_q;
      default:     readdata_d = '0;
    endcase
  end

  assign unused_wdata = &{1'b0, writedata};
  assign readdata     = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed and randomized bench for button_event_ctrl with a cycle-level
// behavioural reference model of the register interface.
module tb_button_event_ctrl;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_in = '1;
  logic [1:0]    address = 2'd0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;

  int n_assert = 0;
  int n_fail   = 0;

  button_event_ctrl #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [NB-1:0] m_sync1, m_sync2, m_stable, m_event, m_mask, m_rep;
  bit [D-1:0]  m_hist [NB];
  int          m_phase [NB];  // 0 released, 1 held waiting, 2 repeating
  int          m_wait  [NB];  // cycles until the next repeat is due
  logic [31:0] m_rd;
  bit          m_irq;

  task automatic model_edge();
    bit [NB-1:0] ev;
    bit [NB-1:0] clr;
    if (reset) begin
      m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_event = '0;
      m_mask = '0; m_rep = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) begin
        m_hist[i] = '0; m_phase[i] = 0; m_wait[i] = 0;
      end
      return;
    end
    ev = '0;
    for (int i = 0; i < NB; i++) begin
      case (m_phase[i])
        0: if (m_stable[i]) begin ev[i] = 1'b1; m_phase[i] = 1; m_wait[i] = RD; end
        1: begin
          if (!m_stable[i]) m_phase[i] = 0;
          else if (m_rep[i] && m_wait[i] == 1) begin ev[i] = 1'b1; m_phase[i] = 2; m_wait[i] = RR; end
          else if (m_wait[i] > 1) m_wait[i]--;
        end
        default: begin
          if (!m_stable[i]) m_phase[i] = 0;
          else if (!m_rep[i]) begin m_phase[i] = 1; m_wait[i] = 1; end
          else if (m_wait[i] == 1) begin ev[i] = 1'b1; m_wait[i] = RR; end
          else m_wait[i]--;
        end
      endcase
    end
    m_rd = '0;
    case (address)
      2'd0: m_rd[NB-1:0] = m_stable;
      2'd1: m_rd[NB-1:0] = m_event;
      2'd2: m_rd[NB-1:0] = m_mask;
      default: m_rd[NB-1:0] = m_rep;
    endcase
    m_irq = |(m_event & m_mask);
    clr = (write && address == 2'd1) ? writedata[NB-1:0] : '0;
    m_event = (m_event & ~clr) | ev;
    if (write && address == 2'd2) m_mask = writedata[NB-1:0];
    if (write && address == 2'd3) m_rep = writedata[NB-1:0];
    // Debounced level follows the synchronised input once it has disagreed for D samples.
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = {m_hist[i][D-2:0], m_sync2[i]};
      if (m_hist[i] == {D{!m_stable[i]}}) m_stable[i] = m_sync2[i];
    end
    m_sync2 = m_sync1;
    m_sync1 = ~btn_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  int          ev_ticks[$];
  int          exp_ticks[6] = '{8, 28, 36, 44, 52, 60};
  bit          prev_b2;
  bit          pend_clr;
  int          noisy;

  initial begin
    // Reset
    ticks(3);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_reset_level", readdata, 32'h0);

    // Clean press on button 0 with MASK=1
    reg_write(2'd2, 32'h1);
    address = 2'd1;
    btn_in[0] = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 9) begin write = 1'b1; writedata = 32'h1; end
      else begin write = 1'b0; writedata = '0; end
      tick();
      if (n == 7) begin
        chk("press_event_early", readdata, 32'h0);
        chk("press_irq_early", {31'b0, irq}, 32'h0);
      end
      if (n == 8) begin
        chk("press_event", readdata, 32'h1);
        chk("press_irq", {31'b0, irq}, 32'h1);
      end
      if (n >= 10) chk("press_no_second", readdata, 32'h0);
    end
    address = 2'd0;
    tick();
    chk("press_level", readdata, 32'h1);
    btn_in[0] = 1'b1;
    ticks(12);

    // Bounce on button 1
    for (int seg = 0; seg < 10; seg++) begin
      btn_in[1] = seg[0];
      for (int k = 0; k < 2; k++) begin
        tick();
        chk("bounce_level", {31'b0, readdata[1]}, 32'h0);
      end
    end
    btn_in[1] = 1'b0;
    address = 2'd1;
    ticks(20);
    chk("bounce_event", readdata, 32'h2);
    reg_write(2'd1, 32'h2);
    ticks(10);
    chk("bounce_single", readdata, 32'h0);
    btn_in[1] = 1'b1;
    ticks(12);

    // Auto-repeat on button 2, events counted via W1C clears
    reg_write(2'd3, 32'h4);
    address = 2'd1;
    btn_in[2] = 1'b0;
    prev_b2 = 1'b0;
    pend_clr = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      if (n == 61) btn_in[2] = 1'b1;
      write = pend_clr; writedata = pend_clr ? 32'h4 : 32'h0;
      pend_clr = 1'b0;
      tick();
      if (readdata[2] && !prev_b2) begin
        if (ev_ticks.size() < 6) chk("repeat_time", n, exp_ticks[ev_ticks.size()]);
        ev_ticks.push_back(n);
        pend_clr = 1'b1;
      end
      prev_b2 = readdata[2];
    end
    write = 1'b0;
    chk("repeat_count", ev_ticks.size(), 6);
    reg_write(2'd3, 32'h0);

    // Set/clear collision on button 0 during repeat
    reg_write(2'd3, 32'h1);
    address = 2'd1;
    btn_in[0] = 1'b0;
    for (int n = 1; n <= 29; n++) begin
      if (n == 27) begin write = 1'b1; writedata = 32'h1; end
      else begin write = 1'b0; writedata = '0; end
      tick();
      if (n >= 27) begin
        chk("collide_event", readdata, 32'h1);
        chk("collide_irq", {31'b0, irq}, 32'h1);
      end
    end
    reg_write(2'd3, 32'h0);
    btn_in[0] = 1'b1;
    ticks(12);
    reg_write(2'd1, 32'hF);

    // Mask and W1C
    btn_in[1:0] = 2'b00;
    ticks(12);
    btn_in[1:0] = 2'b11;
    ticks(12);
    reg_write(2'd2, 32'h2);
    address = 2'd1;
    ticks(2);
    chk("mask_event", readdata, 32'h3);
    chk("mask_irq", {31'b0, irq}, 32'h1);
    reg_write(2'd1, 32'h2);
    chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    chk("w1c_event", readdata, 32'h1);
    chk("w1c_irq_drop", {31'b0, irq}, 32'h0);
    reg_write(2'd1, 32'h0);
    tick();
    chk("w1c_zero", readdata, 32'h1);
    reg_write(2'd0, 32'hF);
    address = 2'd0;
    tick();
    chk("level_ro", readdata, 32'h0);

    // Reset in the middle of a repeat sequence
    reg_write(2'd3, 32'h8);
    address = 2'd1;
    btn_in[3] = 1'b0;
    ticks(38);
    reset = 1'b1;
    ticks(2);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      chk("rst_reg_zero", readdata, 32'h0);
    end
    address = 2'd1;
    ticks(3);
    chk("rst_event_early", readdata, 32'h0);
    tick();
    chk("rst_fresh_event", readdata, 32'h8);
    reg_write(2'd1, 32'h8);
    tick();
    for (int n = 0; n < 40; n++) begin
      tick();
      chk("rst_no_repeat", readdata, 32'h0);
    end
    btn_in[3] = 1'b1;
    ticks(12);

    // Randomized traffic against the reference model
    noisy = 0;
    for (int c = 0; c < 5000; c++) begin
      if (c % 500 == 0) noisy = 30;
      if (noisy > 0) begin
        noisy--;
        if ($urandom_range(0, 2) == 0) begin
          int k = $urandom_range(0, NB - 1);
          btn_in[k] = ~btn_in[k];
        end
      end else if ($urandom_range(0, 39) == 0) begin
        int k = $urandom_range(0, NB - 1);
        btn_in[k] = ~btn_in[k];
      end
      address = 2'($urandom_range(0, 3));
      write = ($urandom_range(0, 5) == 0);
      writedata = write ? $urandom : 32'h0;
      reset = ($urandom_range(0, 1999) == 0);
      tick();
    end
    reset = 1'b0;
    write = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
